// File: rtl/pbvi_pkg.sv
// Shared types, default dimensions and fixed-point helper for the PBVI
// backup pipeline (step-1 Gamma^{a,o} engine and step-2 cross-sum stage).
package pbvi_pkg;

  localparam int DEF_NUM_STATES  = 2;
  localparam int DEF_NUM_ACTIONS = 3;
  localparam int DEF_NUM_OBS     = 2;
  localparam int DEF_NUM_ALPHA   = 16;
  localparam int DEF_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCALE,
    ST_OUTPUT,
    ST_DONE
  } state_t;

  // Unsigned fixed-point multiply with floor truncation; callers keep the
  // product inside 64 bits.
  function automatic logic [63:0] fx_mul(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input int unsigned w);
    return (a * b) >> w;
  endfunction

  // Index width that stays at least one bit for singleton dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pbvi_fx_mac.sv
// Single shared multiply-accumulate: acc += ((t*o)>>W * alpha)>>W per cycle.
module pbvi_fx_mac
  import pbvi_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int ACCW = DEF_W + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [W-1:0]    t,
  input  logic [W-1:0]    o,
  input  logic [W-1:0]    alpha,
  output logic [ACCW-1:0] acc
);

  logic [63:0] p;
  logic [63:0] q;
  logic        unused_hi;

  // Both products are floored independently; q is always below 2^W.
  always_comb begin
    p = fx_mul(64'(t), 64'(o), W);
    q = fx_mul(p, 64'(alpha), W);
  end

  assign unused_hi = ^q[63:ACCW];

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + q[ACCW-1:0];
    end
  end

endmodule

// File: rtl/pbvi_gamma_ao_engine.sv
// Sequential Gamma^{a,o} projection engine: one MAC term per cycle, then a
// discount scale/saturate stage, streaming results over valid/ready.
module pbvi_gamma_ao_engine
  import pbvi_pkg::*;
#(
  parameter int NUM_STATES  = DEF_NUM_STATES,
  parameter int NUM_ACTIONS = DEF_NUM_ACTIONS,
  parameter int NUM_OBS     = DEF_NUM_OBS,
  parameter int NUM_ALPHA   = DEF_NUM_ALPHA,
  parameter int W           = DEF_W,
  localparam int AW         = idx_w(NUM_ACTIONS),
  localparam int OW         = idx_w(NUM_OBS),
  localparam int JW         = idx_w(NUM_ALPHA),
  localparam int SW         = idx_w(NUM_STATES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [W-1:0] discount,
  input  logic [NUM_ALPHA-1:0][NUM_STATES-1:0][W-1:0] alpha,
  input  logic [NUM_ACTIONS-1:0][NUM_STATES-1:0][NUM_STATES-1:0][W-1:0] trans,
  input  logic [NUM_ACTIONS-1:0][NUM_OBS-1:0][NUM_STATES-1:0][W-1:0] observe,
  output logic busy,
  output logic out_valid,
  input  logic out_ready,
  output logic [W-1:0] out_data,
  output logic [AW-1:0] out_a,
  output logic [OW-1:0] out_o,
  output logic [JW-1:0] out_j,
  output logic [SW-1:0] out_s,
  output logic done,
  output logic sat
);

  localparam int ACCW = W + $clog2(NUM_STATES);

  state_t state;

  logic [AW-1:0]   a_q;
  logic [OW-1:0]   o_q;
  logic [JW-1:0]   j_q;
  logic [SW-1:0]   s_q;
  logic [SW-1:0]   sp_q;

  logic [W-1:0]    t_op;
  logic [W-1:0]    o_op;
  logic [W-1:0]    al_op;
  logic [ACCW-1:0] acc;
  logic            mac_clr;
  logic            mac_en;

  logic [63:0]     r_full;
  logic            over;
  logic [W-1:0]    scaled;

  logic a_last, o_last, j_last, s_last, sp_last, tuple_last, fire;

  assign a_last     = (a_q == AW'(NUM_ACTIONS - 1));
  assign o_last     = (o_q == OW'(NUM_OBS - 1));
  assign j_last     = (j_q == JW'(NUM_ALPHA - 1));
  assign s_last     = (s_q == SW'(NUM_STATES - 1));
  assign sp_last    = (sp_q == SW'(NUM_STATES - 1));
  assign tuple_last = a_last && o_last && j_last && s_last;
  assign fire       = (state == ST_OUTPUT) && out_valid && out_ready;

  // Operand selection for the current term s' of tuple (a, o, j, s).
  always_comb begin
    t_op  = trans[a_q][s_q][sp_q];
    o_op  = observe[a_q][o_q][sp_q];
    al_op = alpha[j_q][sp_q];
  end

  // The accumulator sits at zero in IDLE and is cleared again between tuples.
  assign mac_clr = (state == ST_IDLE) || (fire && !tuple_last);
  assign mac_en  = (state == ST_ACCUM);

  pbvi_fx_mac #(
    .W    (W),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .t     (t_op),
    .o     (o_op),
    .alpha (al_op),
    .acc   (acc)
  );

  always_comb begin
    r_full = fx_mul(64'(acc), 64'(discount), W);
    over   = |r_full[63:W];
    scaled = over ? {W{1'b1}} : r_full[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      o_q       <= '0;
      j_q       <= '0;
      s_q       <= '0;
      sp_q      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_a     <= '0;
      out_o     <= '0;
      out_j     <= '0;
      out_s     <= '0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= '0;
            o_q   <= '0;
            j_q   <= '0;
            s_q   <= '0;
            sp_q  <= '0;
            sat   <= 1'b0;
            busy  <= 1'b1;
            state <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          if (sp_last) begin
            sp_q  <= '0;
            state <= ST_SCALE;
          end else begin
            sp_q <= sp_q + 1'b1;
          end
        end

        ST_SCALE: begin
          out_data  <= scaled;
          out_a     <= a_q;
          out_o     <= o_q;
          out_j     <= j_q;
          out_s     <= s_q;
          out_valid <= 1'b1;
          if (over) sat <= 1'b1;
          state <= ST_OUTPUT;
        end

        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (tuple_last) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ACCUM;
              // Odometer advance: s fastest, a slowest.
              if (!s_last) begin
                s_q <= s_q + 1'b1;
              end else begin
                s_q <= '0;
                if (!j_last) begin
                  j_q <= j_q + 1'b1;
                end else begin
                  j_q <= '0;
                  if (!o_last) begin
                    o_q <= o_q + 1'b1;
                  end else begin
                    o_q <= '0;
                    a_q <= a_q + 1'b1;
                  end
                end
              end
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbvi_gamma_ao_engine.sv
// Scoreboard bench for pbvi_gamma_ao_engine: default instance plus a swept
// instance (4 states, 1 action, 3 observations, 5 alpha vectors).
module tb_pbvi_gamma_ao_engine;
  import pbvi_pkg::*;

  localparam int W  = 16;
  localparam int S1 = 2, A1 = 3, O1 = 2, J1 = 16;
  localparam int S2 = 4, A2 = 1, O2 = 3, J2 = 5;

  typedef struct {
    logic [W-1:0] data;
    logic [7:0]   a, o, j, s;
    logic         sat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, ready, sel;
  logic [W-1:0] disc;

  // Reference operand store, sized for the largest instance.
  logic [W-1:0] m_t  [3][4][4];
  logic [W-1:0] m_o  [3][3][4];
  logic [W-1:0] m_al [16][4];

  logic [J1-1:0][S1-1:0][W-1:0]         alpha1;
  logic [A1-1:0][S1-1:0][S1-1:0][W-1:0] trans1;
  logic [A1-1:0][O1-1:0][S1-1:0][W-1:0] observe1;
  logic [J2-1:0][S2-1:0][W-1:0]         alpha2;
  logic [A2-1:0][S2-1:0][S2-1:0][W-1:0] trans2;
  logic [A2-1:0][O2-1:0][S2-1:0][W-1:0] observe2;

  logic busy1, valid1, done1, sat1, start1, ready1;
  logic [W-1:0] data1;
  logic [idx_w(A1)-1:0] a1;
  logic [idx_w(O1)-1:0] o1;
  logic [idx_w(J1)-1:0] j1;
  logic [idx_w(S1)-1:0] s1;

  logic busy2, valid2, done2, sat2, start2, ready2;
  logic [W-1:0] data2;
  logic [idx_w(A2)-1:0] a2;
  logic [idx_w(O2)-1:0] o2;
  logic [idx_w(J2)-1:0] j2;
  logic [idx_w(S2)-1:0] s2;

  assign start1 = (sel == 1'b0) ? start : 1'b0;
  assign ready1 = (sel == 1'b0) ? ready : 1'b0;
  assign start2 = (sel == 1'b1) ? start : 1'b0;
  assign ready2 = (sel == 1'b1) ? ready : 1'b0;

  pbvi_gamma_ao_engine #(
    .NUM_STATES(S1), .NUM_ACTIONS(A1), .NUM_OBS(O1), .NUM_ALPHA(J1), .W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .discount(disc),
    .alpha(alpha1), .trans(trans1), .observe(observe1),
    .busy(busy1), .out_valid(valid1), .out_ready(ready1), .out_data(data1),
    .out_a(a1), .out_o(o1), .out_j(j1), .out_s(s1), .done(done1), .sat(sat1)
  );

  pbvi_gamma_ao_engine #(
    .NUM_STATES(S2), .NUM_ACTIONS(A2), .NUM_OBS(O2), .NUM_ALPHA(J2), .W(W)
  ) dut_sweep (
    .clk(clk), .rst_n(rst_n), .start(start2), .discount(disc),
    .alpha(alpha2), .trans(trans2), .observe(observe2),
    .busy(busy2), .out_valid(valid2), .out_ready(ready2), .out_data(data2),
    .out_a(a2), .out_o(o2), .out_j(j2), .out_s(s2), .done(done2), .sat(sat2)
  );

  logic c_busy, c_valid, c_done, c_sat;
  logic [W-1:0] c_data;
  logic [7:0] c_a, c_o, c_j, c_s;

  always_comb begin
    c_busy = busy1; c_valid = valid1; c_done = done1; c_sat = sat1; c_data = data1;
    c_a = 8'(a1); c_o = 8'(o1); c_j = 8'(j1); c_s = 8'(s1);
    if (sel) begin
      c_busy = busy2; c_valid = valid2; c_done = done2; c_sat = sat2; c_data = data2;
      c_a = 8'(a2); c_o = 8'(o2); c_j = 8'(j2); c_s = 8'(s2);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-term floor truncation, then discount scale; saturation left to caller.
  function automatic longint unsigned model_raw(int a, int o, int j, int s, int ns);
    longint unsigned acc, p, q;
    acc = 0;
    for (int sp = 0; sp < ns; sp++) begin
      p   = (64'(m_t[a][s][sp]) * 64'(m_o[a][o][sp])) >> W;
      q   = (p * 64'(m_al[j][sp])) >> W;
      acc = acc + q;
    end
    return (acc * 64'(disc)) >> W;
  endfunction

  task automatic pack_ports();
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 4; s++)
        for (int sp = 0; sp < 4; sp++) begin
          if (a < A1 && s < S1 && sp < S1) trans1[a][s][sp] = m_t[a][s][sp];
          if (a < A2 && s < S2 && sp < S2) trans2[a][s][sp] = m_t[a][s][sp];
        end
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 3; o++)
        for (int sp = 0; sp < 4; sp++) begin
          if (a < A1 && o < O1 && sp < S1) observe1[a][o][sp] = m_o[a][o][sp];
          if (a < A2 && o < O2 && sp < S2) observe2[a][o][sp] = m_o[a][o][sp];
        end
    for (int j = 0; j < 16; j++)
      for (int sp = 0; sp < 4; sp++) begin
        if (j < J1 && sp < S1) alpha1[j][sp] = m_al[j][sp];
        if (j < J2 && sp < S2) alpha2[j][sp] = m_al[j][sp];
      end
  endtask

  task automatic fill(input bit rnd, input logic [W-1:0] tv, input logic [W-1:0] ov,
                      input logic [W-1:0] alv, input logic [W-1:0] dv);
    for (int a = 0; a < 3; a++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++) begin
          m_t[a][x][y] = rnd ? 16'($urandom) : tv;
          if (x < 3) m_o[a][x][y] = rnd ? 16'($urandom) : ov;
        end
    for (int j = 0; j < 16; j++)
      for (int y = 0; y < 4; y++) m_al[j][y] = rnd ? 16'($urandom) : alv;
    disc = rnd ? 16'($urandom) : dv;
    pack_ports();
  endtask

  // One full run on the selected instance; pct is the out_ready duty in %.
  task automatic run(input string name, input int na, input int no, input int nj,
                     input int ns, input int pct, input int mid_start);
    exp_t e;
    longint unsigned raw;
    logic sat_acc, pstall, finished;
    logic [63:0] snap, now;
    int cyc, got, dones, done_cyc, total, budget;
    sat_acc = 1'b0; pstall = 1'b0; finished = 1'b0; snap = '0;
    got = 0; dones = 0; done_cyc = -1;
    sb.delete();
    for (int a = 0; a < na; a++)
      for (int o = 0; o < no; o++)
        for (int j = 0; j < nj; j++)
          for (int s = 0; s < ns; s++) begin
            raw = model_raw(a, o, j, s, ns);
            e.data = (raw > 64'hFFFF) ? 16'hFFFF : raw[W-1:0];
            sat_acc = sat_acc | (raw > 64'hFFFF);
            e.a = 8'(a); e.o = 8'(o); e.j = 8'(j); e.s = 8'(s); e.sat = sat_acc;
            sb.push_back(e);
          end
    total  = sb.size();
    budget = total * (ns + 2) * 6 + 100;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!finished && cyc < budget) begin
      ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      start = (mid_start > 0 && cyc == mid_start);
      @(negedge clk);
      now = {8'(c_valid), c_data, c_a, c_o, c_j, c_s};
      if (cyc == 0) check({name, "_busy_after_start"}, 64'(c_busy), 64'd1);
      if (pstall) check({name, "_stall_hold"}, now, snap);
      if (c_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (dones > 0) begin
        check({name, "_busy_after_done"}, 64'(c_busy), 64'd0);
        finished = 1'b1;
      end
      if (c_valid && ready) begin
        if (pct >= 100)
          check({name, "_result_latency"}, 64'(cyc), 64'(ns + 1 + got * (ns + 2)));
        if (sb.size() == 0) begin
          check({name, "_extra_result"}, 64'(got), 64'(total));
        end else begin
          e = sb.pop_front();
          check({name, "_result"}, {c_data, c_a, c_o, c_j, c_s},
                {e.data, e.a, e.o, e.j, e.s});
          check({name, "_sat_progress"}, 64'(c_sat), 64'(e.sat));
        end
        got++;
      end
      pstall = c_valid && !ready;
      snap   = now;
      @(posedge clk); cyc++; #1;
    end
    start = 1'b0;
    ready = 1'b0;
    check({name, "_finished_in_budget"}, 64'(finished), 64'd1);
    check({name, "_done_count"}, 64'(dones), 64'd1);
    check({name, "_result_count"}, 64'(got), 64'(total));
    check({name, "_final_sat"}, 64'(c_sat), 64'(sat_acc));
    if (pct >= 100)
      check({name, "_done_cycle"}, 64'(done_cyc), 64'(total * (ns + 2) + 1));
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0; disc = '0;
    fill(1'b0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut", {busy1, valid1, data1, a1, o1, j1, s1, done1, sat1}, 64'd0);
    check("reset_sweep", {busy2, valid2, data2, a2, o2, j2, s2, done2, sat2}, 64'd0);
    rst_n = 1'b1;

    // Basic value: every result 0x0799, no saturation.
    fill(1'b0, 16'h8000, 16'h8000, 16'h1000, 16'hF333);
    run("basic", A1, O1, J1, S1, 100, 0);

    // Full-scale operands: acc 0x1FFFA scales to 0x1FFF8 and clamps.
    fill(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run("saturate", A1, O1, J1, S1, 100, 0);

    fill(1'b1, '0, '0, '0, '0);
    run("backpressure", A1, O1, J1, S1, 70, 0);

    fill(1'b1, '0, '0, '0, '0);
    run("start_busy", A1, O1, J1, S1, 100, 50);

    // Abort while a result is held, then rerun from scratch.
    fill(1'b1, '0, '0, '0, '0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!valid1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("reset_mid_reached_output", 64'(valid1), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {busy1, valid1, data1, a1, o1, j1, s1, done1, sat1}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run("after_reset", A1, O1, J1, S1, 100, 0);

    sel = 1'b1;
    fill(1'b1, '0, '0, '0, '0);
    run("sweep", A2, O2, J2, S2, 100, 0);
    fill(1'b1, '0, '0, '0, '0);
    run("sweep_bp", A2, O2, J2, S2, 60, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
